// File: rtl/ahbl_apb_bridge_if.sv
// AHB-Lite slave-side and APB master-side bus bundles for ahbl_apb_bridge.
// pprot/pstrb exist only when AHBL_APB_BRIDGE_APB4_EN is defined.

interface ahbl_if;
  logic        hsel;
  logic        hreadyin;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, hreadyin, haddr, hwrite, hsize, hprot, htrans, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  hsel, hreadyin, haddr, hwrite, hsize, hprot, htrans, hwdata,
    output hready, hresp, hrdata
  );
endinterface

interface apb_if #(
  parameter int PADDR_WIDTH = 16
);
  logic                   psel;
  logic                   penable;
  logic [PADDR_WIDTH-1:0] paddr;
  logic                   pwrite;
  logic [31:0]            pwdata;
  logic [31:0]            prdata;
  logic                   pready;
  logic                   pslverr;
`ifdef AHBL_APB_BRIDGE_APB4_EN
  logic [2:0]             pprot;
  logic [3:0]             pstrb;
`endif

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
`ifdef AHBL_APB_BRIDGE_APB4_EN
    output pprot, pstrb,
`endif
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
`ifdef AHBL_APB_BRIDGE_APB4_EN
    input  pprot, pstrb,
`endif
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB master bridge, 32-bit data; APB4 pprot/pstrb under AHBL_APB_BRIDGE_APB4_EN.
// Latency: read 2 wait states, write 3, plus one per pready-low ACCESS cycle.
// Backpressure: hready held low until the APB access completes; pslverr becomes a two-cycle ERROR.

module ahbl_apb_bridge #(
  parameter int PADDR_WIDTH = 16
) (
  input  logic   hclk,
  input  logic   hreset,
  ahbl_if.slave  ahb,
  apb_if.master  apb
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WLAT   = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_t;

  state_t                 state;
  logic                   hready_q;
  logic                   hresp_q;
  logic [31:0]            hrdata_q;
  logic                   psel_q;
  logic                   penable_q;
  logic [PADDR_WIDTH-1:0] paddr_q;
  logic                   pwrite_q;
  logic [31:0]            pwdata_q;
`ifdef AHBL_APB_BRIDGE_APB4_EN
  logic [2:0]             pprot_q;
  logic [3:0]             pstrb_q;
`endif

  logic valid;
  logic unused_ok;

  assign valid = ahb.hsel & ahb.hreadyin & ahb.htrans[1];

  // Upper address bits, burst hints and (in APB3 builds) size/prot are intentionally dropped.
  assign unused_ok = ^{ahb.haddr, ahb.hsize, ahb.hprot, ahb.htrans};

`ifdef AHBL_APB_BRIDGE_APB4_EN
  function automatic logic [3:0] strb_of(input logic wr, input logic [2:0] sz,
                                         input logic [1:0] a);
    logic [3:0] s;
    if (!wr) begin
      s = 4'b0000;
    end else begin
      case (sz)
        3'd0:    s = 4'b0001 << a;
        3'd1:    s = 4'b0011 << {a[1], 1'b0};
        default: s = 4'b1111;
      endcase
    end
    return s;
  endfunction
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= IDLE;
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
      hrdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
`ifdef AHBL_APB_BRIDGE_APB4_EN
      pprot_q   <= '0;
      pstrb_q   <= '0;
`endif
    end else begin
      case (state)
        // ERR2 is the last ERROR cycle, so it may already carry the next address phase.
        IDLE, ERR2: begin
          hresp_q <= 1'b0;
          if (valid) begin
            paddr_q  <= ahb.haddr[PADDR_WIDTH-1:0];
            pwrite_q <= ahb.hwrite;
`ifdef AHBL_APB_BRIDGE_APB4_EN
            pprot_q  <= {~ahb.hprot[0], 1'b0, ahb.hprot[1]};
            pstrb_q  <= strb_of(ahb.hwrite, ahb.hsize, ahb.haddr[1:0]);
`endif
            hready_q <= 1'b0;
            if (ahb.hwrite) begin
              state <= WLAT;
            end else begin
              state  <= SETUP;
              psel_q <= 1'b1;
            end
          end else begin
            hready_q <= 1'b1;
            state    <= IDLE;
          end
        end

        // hwdata is only valid in the data phase, one cycle after the address.
        WLAT: begin
          pwdata_q <= ahb.hwdata;
          psel_q   <= 1'b1;
          state    <= SETUP;
        end

        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end

        ACCESS: begin
          if (apb.pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (apb.pslverr) begin
              hresp_q <= 1'b1;
              state   <= ERR1;
            end else begin
              hready_q <= 1'b1;
              if (!pwrite_q) begin
                hrdata_q <= apb.prdata;
              end
              state <= IDLE;
            end
          end
        end

        ERR1: begin
          hready_q <= 1'b1;
          state    <= ERR2;
        end

        default: begin
          state     <= IDLE;
          hready_q  <= 1'b1;
          hresp_q   <= 1'b0;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign ahb.hready  = hready_q;
  assign ahb.hresp   = hresp_q;
  assign ahb.hrdata  = hrdata_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
`ifdef AHBL_APB_BRIDGE_APB4_EN
  assign apb.pprot   = pprot_q;
  assign apb.pstrb   = pstrb_q;
`endif

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Bench for ahbl_apb_bridge: directed AHB transfers push expected responses into queues,
// and independent AHB/APB monitors pop and compare as the bridge presents them.

module tb_ahbl_apb_bridge;
  localparam int PADDR_WIDTH = 16;

  logic hclk = 1'b0;
  logic hreset;

  ahbl_if ahb ();
  apb_if #(.PADDR_WIDTH(PADDR_WIDTH)) apb ();

  ahbl_apb_bridge #(.PADDR_WIDTH(PADDR_WIDTH)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .ahb    (ahb),
    .apb    (apb)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    int          waits;
    logic        resp;
    logic [31:0] rdata;
  } ahb_exp_t;

  typedef struct {
    logic [15:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } apb_exp_t;

  ahb_exp_t ahb_q[$];
  apb_exp_t apb_q[$];

  int checks = 0;
  int errors = 0;
  int stall_left = 0;

  int   mon_low = 0;
  logic mon_prev_rdy = 1'b1;
  logic mon_prev_err2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // APB slave: pready low for stall_left ACCESS cycles, then high.
  initial begin
    apb.pready = 1'b1;
    forever begin
      @(posedge hclk);
      #1;
      if (apb.psel && apb.penable && stall_left > 0) begin
        apb.pready = 1'b0;
        stall_left--;
      end else begin
        apb.pready = 1'b1;
      end
    end
  end

  // AHB monitor: a low-to-high hready closes a data phase.
  initial begin
    ahb_exp_t e;
    forever begin
      @(negedge hclk);
      if (hreset) begin
        mon_low       = 0;
        mon_prev_rdy  = 1'b1;
        mon_prev_err2 = 1'b0;
      end else begin
        if (mon_prev_err2) check("hresp_after_err2", ahb.hresp, 1'b0);
        mon_prev_err2 = 1'b0;
        if (!ahb.hready) begin
          mon_low++;
          if (ahb_q.size() > 0 && ahb_q[0].resp && mon_low == ahb_q[0].waits)
            check("hresp_err1", ahb.hresp, 1'b1);
          else
            check("hresp_wait", ahb.hresp, 1'b0);
        end else if (!mon_prev_rdy) begin
          if (ahb_q.size() == 0) begin
            fail("unexpected_ahb_completion");
          end else begin
            e = ahb_q.pop_front();
            check("wait_states", mon_low, e.waits);
            check("hresp", ahb.hresp, e.resp);
            check("hrdata", ahb.hrdata, e.rdata);
            mon_prev_err2 = ahb.hresp;
          end
          mon_low = 0;
        end
        mon_prev_rdy = ahb.hready;
      end
    end
  end

  // APB monitor: every SETUP/ACCESS cycle must show the front request's fields.
  initial begin
    apb_exp_t x;
    forever begin
      @(negedge hclk);
      if (!hreset && apb.psel) begin
        if (apb_q.size() == 0) begin
          fail("unexpected_psel");
        end else begin
          x = apb_q[0];
          check(apb.penable ? "paddr_access" : "paddr_setup", apb.paddr, x.paddr);
          check("pwrite", apb.pwrite, x.pwrite);
          if (x.pwrite) check("pwdata", apb.pwdata, x.pwdata);
`ifdef AHBL_APB_BRIDGE_APB4_EN
          check("pstrb", apb.pstrb, x.pstrb);
          check("pprot", apb.pprot, x.pprot);
`endif
          if (apb.penable && apb.pready) apb_q.delete(0);
        end
      end
    end
  end

  // Drive one address phase (caller is in a cycle with hready=1) and queue expectations.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [3:0] prot, input logic [31:0] wdata,
                       input int waits, input logic resp, input logic [31:0] rdata,
                       input logic [3:0] strb, input logic [2:0] pprot_exp);
    ahb_exp_t e;
    apb_exp_t x;
    e.waits = waits; e.resp = resp; e.rdata = rdata;
    x.paddr = addr[15:0]; x.pwrite = wr; x.pwdata = wdata; x.pstrb = strb; x.pprot = pprot_exp;
    ahb_q.push_back(e);
    apb_q.push_back(x);
    ahb.hsel   = 1'b1;
    ahb.htrans = 2'b10;
    ahb.haddr  = addr;
    ahb.hwrite = wr;
    ahb.hsize  = size;
    ahb.hprot  = prot;
    @(posedge hclk);
    #1;
    ahb.hsel   = 1'b0;
    ahb.htrans = 2'b00;
    ahb.hwdata = wdata;
  endtask

  // Wait for the current data phase to reach its hready=1 cycle.
  task automatic data_phase();
    int n = 0;
    while (!ahb.hready && n < 100) begin
      @(posedge hclk);
      #1;
      n++;
    end
    if (n >= 100) fail("hready_timeout");
  endtask

  task automatic idle_cycle();
    @(posedge hclk);
    #1;
  endtask

  logic [3:0] pat_tab [8];

  initial begin
    int n;
    hreset       = 1'b1;
    ahb.hsel     = 1'b0;
    ahb.hreadyin = 1'b1;
    ahb.htrans   = 2'b00;
    ahb.haddr    = '0;
    ahb.hwrite   = 1'b0;
    ahb.hsize    = 3'd2;
    ahb.hprot    = 4'b0011;
    ahb.hwdata   = '0;
    apb.prdata   = '0;
    apb.pslverr  = 1'b0;

    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_hready", ahb.hready, 1'b1);
    check("rst_hresp", ahb.hresp, 1'b0);
    check("rst_hrdata", ahb.hrdata, 32'h0);
    check("rst_psel", apb.psel, 1'b0);
    check("rst_penable", apb.penable, 1'b0);
    check("rst_paddr", apb.paddr, 16'h0);
    check("rst_pwrite", apb.pwrite, 1'b0);
    check("rst_pwdata", apb.pwdata, 32'h0);
`ifdef AHBL_APB_BRIDGE_APB4_EN
    check("rst_pstrb", apb.pstrb, 4'h0);
    check("rst_pprot", apb.pprot, 3'h0);
`endif
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    idle_cycle();

    // Read, zero-wait APB
    apb.prdata = 32'hDEADBEEF;
    issue(32'h0000_1234, 1'b0, 3'd2, 4'b0011, 32'h0, 2, 1'b0, 32'hDEADBEEF, 4'b0000, 3'b001);
    data_phase();
    idle_cycle();

    // Write with three pready-low ACCESS cycles
    stall_left = 3;
    issue(32'h0000_0040, 1'b1, 3'd2, 4'b0011, 32'hA5A5_0001, 6, 1'b0, 32'hDEADBEEF, 4'b1111, 3'b001);
    data_phase();
    idle_cycle();

    // Read with pslverr: ERROR response, hrdata kept
    apb.prdata  = 32'h1234_5678;
    apb.pslverr = 1'b1;
    issue(32'h0000_0100, 1'b0, 3'd2, 4'b0011, 32'h0, 3, 1'b1, 32'hDEADBEEF, 4'b0000, 3'b001);
    data_phase();
    idle_cycle();
    apb.pslverr = 1'b0;
    idle_cycle();

    // Back-to-back write then read, second address in write's final cycle
    apb.prdata = 32'hCAFE_0002;
    issue(32'h0000_0080, 1'b1, 3'd2, 4'b0011, 32'h0BAD_F00D, 3, 1'b0, 32'hDEADBEEF, 4'b1111, 3'b001);
    data_phase();
    issue(32'h0000_0084, 1'b0, 3'd2, 4'b0011, 32'h0, 2, 1'b0, 32'hCAFE_0002, 4'b0000, 3'b001);
    data_phase();
    idle_cycle();

    // Byte write at offset 2, halfword write at offset 2, truncated-address read
    issue(32'h0000_0042, 1'b1, 3'd0, 4'b0000, 32'h00AB_0000, 3, 1'b0, 32'hCAFE_0002, 4'b0100, 3'b100);
    data_phase();
    issue(32'h0000_0046, 1'b1, 3'd1, 4'b0010, 32'h1234_0000, 3, 1'b0, 32'hCAFE_0002, 4'b1100, 3'b101);
    data_phase();
    apb.prdata = 32'h0055_AA00;
    issue(32'hFFFF_5678, 1'b0, 3'd2, 4'b0011, 32'h0, 2, 1'b0, 32'h0055_AA00, 4'b0000, 3'b001);
    data_phase();
    idle_cycle();

    // Write error, then a read accepted during ERR2
    apb.pslverr = 1'b1;
    issue(32'h0000_0200, 1'b1, 3'd2, 4'b0011, 32'h0000_0001, 4, 1'b1, 32'h0055_AA00, 4'b1111, 3'b001);
    data_phase();
    apb.pslverr = 1'b0;
    apb.prdata  = 32'h0000_0010;
    issue(32'h0000_0010, 1'b0, 3'd2, 4'b0011, 32'h0, 2, 1'b0, 32'h0000_0010, 4'b0000, 3'b001);
    data_phase();
    idle_cycle();

    // Ignored transfers: {hsel, hreadyin, htrans}
    pat_tab[0] = 4'b1100; pat_tab[1] = 4'b1100; pat_tab[2] = 4'b1101; pat_tab[3] = 4'b1010;
    pat_tab[4] = 4'b1011; pat_tab[5] = 4'b1010; pat_tab[6] = 4'b0110; pat_tab[7] = 4'b0111;
    for (int i = 0; i < 8; i++) begin
      ahb.hsel     = pat_tab[i][3];
      ahb.hreadyin = pat_tab[i][2];
      ahb.htrans   = pat_tab[i][1:0];
      ahb.haddr    = 32'h0000_0300;
      @(negedge hclk);
      check("ignored_psel", apb.psel, 1'b0);
      check("ignored_hready", ahb.hready, 1'b1);
      idle_cycle();
    end
    ahb.hsel     = 1'b0;
    ahb.hreadyin = 1'b1;
    ahb.htrans   = 2'b00;
    @(negedge hclk);
    check("ignored_psel_last", apb.psel, 1'b0);
    check("ignored_hready_last", ahb.hready, 1'b1);
    idle_cycle();

    // Reset during a stalled ACCESS
    stall_left = 5;
    apb.prdata = 32'h7777_7777;
    issue(32'h0000_0020, 1'b0, 3'd2, 4'b0011, 32'h0, 7, 1'b0, 32'h7777_7777, 4'b0000, 3'b001);
    n = 0;
    while (!(apb.psel && apb.penable) && n < 20) begin
      idle_cycle();
      n++;
    end
    if (n >= 20) fail("access_timeout");
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    ahb_q.delete();
    apb_q.delete();
    stall_left = 0;
    @(negedge hclk);
    check("abort_psel", apb.psel, 1'b0);
    check("abort_penable", apb.penable, 1'b0);
    check("abort_hready", ahb.hready, 1'b1);
    check("abort_hresp", ahb.hresp, 1'b0);
    check("abort_hrdata", ahb.hrdata, 32'h0);
    check("abort_paddr", apb.paddr, 16'h0);
    check("abort_pwdata", apb.pwdata, 32'h0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    idle_cycle();

    // Recovery read after reset
    apb.prdata = 32'h600D_0001;
    issue(32'h0000_0004, 1'b0, 3'd2, 4'b0011, 32'h0, 2, 1'b0, 32'h600D_0001, 4'b0000, 3'b001);
    data_phase();
    repeat (3) idle_cycle();

    check("ahb_queue_drained", ahb_q.size(), 0);
    check("apb_queue_drained", apb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbl_apb_bridge.md
Name: ahbl_apb_bridge

Overview:
- AHB-Lite slave to APB master bridge, sitting directly downstream of the AHB-Lite bus (slave-side signal set) and feeding APB peripherals (UART, GPIO, timers).
- Converts each AHB-Lite single transfer into one APB SETUP/ACCESS pair. Inserts AHB wait states until the APB completes.
- Maps `pslverr` onto the two-cycle AHB-Lite ERROR response.
- Data width fixed at 32 bits.

Parameters:
- `PADDR_WIDTH`, 16: APB address width. `paddr` = `haddr[PADDR_WIDTH-1:0]`.

Ports:
- `hclk`  in  1  clock; all logic on rising edge
- `hreset`  in  1  synchronous active-high reset
- `hsel`  in  1  slave select from AHB decoder
- `hreadyin`  in  1  bus-level hready (previous data phase complete)
- `haddr`  in  32  address
- `hwrite`  in  1  1 = write
- `hsize`  in  3  transfer size
- `hprot`  in  4  protection
- `htrans`  in  2  transfer type
- `hwdata`  in  32  write data (data phase)
- `hready`  out  1  slave ready
- `hresp`  out  1  0 = OKAY, 1 = ERROR
- `hrdata`  out  32  read data
- `psel`  out  1  APB select
- `penable`  out  1  APB enable
- `paddr`  out  PADDR_WIDTH  APB address
- `pwrite`  out  1  APB direction
- `pwdata`  out  32  APB write data
- `prdata`  in  32  APB read data
- `pready`  in  1  APB ready
- `pslverr`  in  1  APB slave error

Behaviour:
- Interface: one clock, `hclk`. Reset `hreset` is synchronous and active-high.
- Reset values: `hready`=1; `hresp`=0; `hrdata`, `paddr`, `pwdata`=0; `psel`, `penable`, `pwrite`=0; state IDLE.
- Reset asserted mid-transfer aborts the APB access: next cycle all outputs are at reset values.
- Accept condition: `valid` = `hsel & hreadyin & htrans[1]` (NONSEQ or SEQ).
  - IDLE/BUSY, or `hsel` with `hreadyin`=0, is ignored.
  - An ignored transfer gets a zero-wait OKAY (`hready` stays 1).
  - `hburst` and `hmastrlock` are not used; each beat is treated as an independent single transfer.
- On `valid` at a rising edge: register `paddr`, `pwrite` (and the APB4 fields, when enabled).
  - Next state is WLAT if `hwrite`=1, SETUP if `hwrite`=0.
- FSM states:
  - IDLE:
    - `hready`=1, `hresp`=0, `psel`=0.
    - Sampling `valid` here pipelines the next address.
  - WLAT:
    - `hready`=0, `psel`=0.
    - Latch `pwdata` <= `hwdata`, go to SETUP.
  - SETUP:
    - `psel`=1, `penable`=0, `hready`=0.
    - Always go to ACCESS.
  - ACCESS:
    - `psel`=1, `penable`=1, `hready`=0.
    - Hold while `pready`=0; `paddr`/`pwrite`/`pwdata` stay stable.
    - On `pready`=1 & `pslverr`=0: if read, `hrdata` <= `prdata`; go to IDLE.
    - On `pready`=1 & `pslverr`=1: go to ERR1; `hrdata` is unchanged.
  - ERR1: `hready`=0, `hresp`=1, `psel`=0, go to ERR2.
  - ERR2:
    - `hready`=1, `hresp`=1.
    - A `valid` sampled here is accepted as in IDLE; the master drives IDLE to cancel.
    - Otherwise go to IDLE.
- `psel`/`penable` drop in the cycle after the ACCESS completion edge; there are no idle APB cycles between back-to-back transfers beyond those the FSM imposes.
- Latency with `pready` tied to 1:
  - Read: 2 AHB wait states (address T0, SETUP T1, ACCESS T2, data phase ends T3 with `hrdata` valid).
  - Write: 3 wait states.
  - Each `pready`=0 cycle adds one wait state.
- Outside a completing read, `hrdata` holds its last value.
- `haddr` bits above `PADDR_WIDTH` are discarded with no range check; decoding belongs upstream.

Optional Feature:
- Macro: `AHBL_APB_BRIDGE_APB4_EN`.
- When defined, adds two outputs:
  - `pprot` [2:0] = {~`hprot[0]`, 1'b0, `hprot[1]`}, registered with `paddr`.
  - `pstrb` [3:0], registered at the address phase:
    - Reads: 0.
    - Writes, byte (`hsize`=0): 1 << `haddr[1:0]`.
    - Writes, halfword (`hsize`=1): 4'b0011 << {`haddr[1]`, 1'b0}.
    - Writes, word: 4'b1111.
  - Both reset to 0.
- When undefined, the ports and logic are absent; behaviour is pure APB3.

Test Plan:
- Read, `pready`=1, `prdata`=32'hDEADBEEF at `haddr`=32'h0000_1234 -> `paddr`=16'h1234; `psel` high T1–T2, `penable` high T2; `hready` low T1–T2; T3 `hready`=1, `hrdata`=32'hDEADBEEF, `hresp`=0.
- Write 32'hA5A5_0001 to 32'h40, `pready` low for 3 ACCESS cycles -> `pwdata`=32'hA5A5_0001 stable from SETUP through ACCESS; `hready` low for 6 cycles, then 1.
- Read with `pready`=1, `pslverr`=1 -> ERR1 (`hready`=0, `hresp`=1), then ERR2 (`hready`=1, `hresp`=1), then IDLE `hresp`=0; `hrdata` unchanged.
- Back-to-back write then read, with the second NONSEQ driven in the write's final `hready`=1 cycle -> second SETUP starts the next cycle; both complete correctly.
- `htrans`=IDLE with `hsel`=1, and NONSEQ with `hreadyin`=0 -> `psel` never asserts; `hready` stays 1.
- `hreset` asserted during ACCESS -> next cycle `psel`=`penable`=0, `hready`=1, `hrdata`=0; with APB4_EN, a byte write to address offset 2 gives `pstrb`=4'b0100.
